// File: rtl/audio_in_pkg.sv
// Shared types and default sizing for the audio ADC receive path.
package audio_in_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } audio_in_state_e;

    localparam int DEFAULT_AUDIO_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH       = 128;
    localparam int DEFAULT_FIFO_ADDR_WIDTH  = 7;
    localparam int READ_SPACE_W             = 8;

endpackage

// File: rtl/audio_in_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is held in a register that
// is refreshed from the array at the next read pointer, so the storage
// keeps a registered read; a write into an otherwise empty slot bypasses
// the array so the new word is at the head one cycle after the write.
module audio_in_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] used
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] head_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_write, do_read, bypass;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (ADDR_WIDTH+1)'(DATA_DEPTH));
    assign used      = count_q[ADDR_WIDTH-1:0];
    assign read_data = head_q;

    // Qualify requests, advance pointers with wrap, and track occupancy.
    always_comb begin
        do_write = write_en && !full;
        do_read  = read_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (do_read) begin
            rd_ptr_d = (rd_ptr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        // The incoming word becomes the head only when it is the sole entry.
        bypass = do_write && (count_d == (ADDR_WIDTH+1)'(1));
    end

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    // Pointer/count state and the show-ahead head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (bypass) begin
                head_q <= write_data;
            end else if (count_d != '0) begin
                head_q <= mem_q[rd_ptr_d];
            end
        end
    end

endmodule

// File: rtl/audio_in_deserializer.sv
// Left-justified, MSB-first ADCDAT receiver. Captures a left and a right
// frame per LRCLK period and commits the stereo pair into two FIFOs.
// Optional build macro AUDIO_IN_OVERFLOW_CNT_EN adds a saturating count
// of pairs dropped because a FIFO was full.
module audio_in_deserializer
    import audio_in_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = DEFAULT_AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH       = DEFAULT_FIFO_DEPTH,
    parameter int FIFO_ADDR_WIDTH  = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_clk_rising_edge,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        serial_audio_in_data,
    input  logic                        left_channel_read_en,
    input  logic                        right_channel_read_en,
    output logic [READ_SPACE_W-1:0]     left_channel_fifo_read_space,
    output logic [READ_SPACE_W-1:0]     right_channel_fifo_read_space,
    output logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    output logic [AUDIO_DATA_WIDTH-1:0] right_channel_data
`ifdef AUDIO_IN_OVERFLOW_CNT_EN
    ,
    output logic [15:0]                 overflow_count
`endif
);

    localparam int IDX_W = $clog2(AUDIO_DATA_WIDTH);
    localparam int CNT_W = IDX_W + 1;

    audio_in_state_e             state_q;
    logic                        din_q;
    logic [CNT_W-1:0]            bit_cnt_q;
    logic [AUDIO_DATA_WIDTH-1:0] left_shift_q, right_shift_q, left_hold_q;
    logic [READ_SPACE_W-1:0]     left_space_q, right_space_q;

    logic                        sample, commit_try, commit, drop;
    logic [IDX_W-1:0]            bit_idx;
    logic                        l_empty, l_full, r_empty, r_full;
    logic [FIFO_ADDR_WIDTH-1:0]  l_used, r_used;

    // Bit position for the next sample and pair commit/drop decisions.
    always_comb begin
        sample     = bit_clk_rising_edge && (bit_cnt_q < CNT_W'(AUDIO_DATA_WIDTH));
        bit_idx    = IDX_W'(AUDIO_DATA_WIDTH - 1) - bit_cnt_q[IDX_W-1:0];
        commit_try = left_right_clk_rising_edge && (state_q == RIGHT);
        commit     = commit_try && !l_full && !r_full;
        drop       = commit_try && !commit;
    end

    // Single register stage on the codec data line.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= serial_audio_in_data;
        end
    end

    // Frame FSM and capture; an LR edge always beats a coincident bit strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            left_shift_q  <= '0;
            right_shift_q <= '0;
            left_hold_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (left_right_clk_rising_edge) begin
                        state_q      <= LEFT;
                        bit_cnt_q    <= '0;
                        left_shift_q <= '0;
                    end
                end
                LEFT: begin
                    if (left_right_clk_rising_edge) begin
                        // Falling edge was missed: restart the left frame.
                        bit_cnt_q    <= '0;
                        left_shift_q <= '0;
                    end else if (left_right_clk_falling_edge) begin
                        state_q       <= RIGHT;
                        left_hold_q   <= left_shift_q;
                        bit_cnt_q     <= '0;
                        right_shift_q <= '0;
                    end else if (sample) begin
                        left_shift_q[bit_idx] <= din_q;
                        bit_cnt_q             <= bit_cnt_q + CNT_W'(1);
                    end
                end
                RIGHT: begin
                    if (left_right_clk_rising_edge) begin
                        state_q      <= LEFT;
                        bit_cnt_q    <= '0;
                        left_shift_q <= '0;
                    end else if (left_right_clk_falling_edge) begin
                        bit_cnt_q     <= '0;
                        right_shift_q <= '0;
                    end else if (sample) begin
                        right_shift_q[bit_idx] <= din_q;
                        bit_cnt_q              <= bit_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    audio_in_sync_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .DATA_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_left_fifo (
        .clk        (clk),
        .reset      (reset),
        .write_en   (commit),
        .write_data (left_hold_q),
        .read_en    (left_channel_read_en),
        .read_data  (left_channel_data),
        .empty      (l_empty),
        .full       (l_full),
        .used       (l_used)
    );

    audio_in_sync_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .DATA_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_right_fifo (
        .clk        (clk),
        .reset      (reset),
        .write_en   (commit),
        .write_data (right_shift_q),
        .read_en    (right_channel_read_en),
        .read_data  (right_channel_data),
        .empty      (r_empty),
        .full       (r_full),
        .used       (r_used)
    );

    // Registered read-space, one cycle behind the FIFO occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_space_q  <= '0;
            right_space_q <= '0;
        end else begin
            left_space_q  <= READ_SPACE_W'({l_full, l_used});
            right_space_q <= READ_SPACE_W'({r_full, r_used});
        end
    end

    assign left_channel_fifo_read_space  = left_space_q;
    assign right_channel_fifo_read_space = right_space_q;

`ifdef AUDIO_IN_OVERFLOW_CNT_EN
    logic [15:0] overflow_q;

    // Saturating count of stereo pairs dropped on a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= '0;
        end else if (drop && (overflow_q != 16'hFFFF)) begin
            overflow_q <= overflow_q + 16'd1;
        end
    end

    assign overflow_count = overflow_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    // Strobe sanity: BCLK cannot rise and fall in the same cycle, and the
    // FIFO flags must stay coherent with their occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bit_clk_rising_edge && bit_clk_falling_edge));
            assert (!(l_empty && (l_full || l_used != '0)));
            assert (!(r_empty && (r_full || r_used != '0)));
        end
    end

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Directed/randomized bench for audio_in_deserializer with a frame-level
// reference model (per-frame bit lists justified into words, FIFO queues).
module tb_audio_in_deserializer;

    localparam int W     = 32;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bclk_r = 1'b0, bclk_f = 1'b0, lr_r = 1'b0, lr_f = 1'b0;
    logic        sdata = 1'b0, rd_l = 1'b0, rd_r = 1'b0;
    logic [7:0]  rs_l, rs_r;
    logic [31:0] dat_l, dat_r;
`ifdef AUDIO_IN_OVERFLOW_CNT_EN
    logic [15:0] ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] ql[$];
    logic [31:0] qr[$];
    bit          fbits[$];
    int          phase = 0;        // 0: no frame yet, 1: left frame, 2: right frame
    logic [31:0] left_word = '0;
    int          m_ovf = 0;

    always #5 clk = ~clk;

    audio_in_deserializer dut (
        .clk                           (clk),
        .reset                         (reset),
        .bit_clk_rising_edge           (bclk_r),
        .bit_clk_falling_edge          (bclk_f),
        .left_right_clk_rising_edge    (lr_r),
        .left_right_clk_falling_edge   (lr_f),
        .serial_audio_in_data          (sdata),
        .left_channel_read_en          (rd_l),
        .right_channel_read_en         (rd_r),
        .left_channel_fifo_read_space  (rs_l),
        .right_channel_fifo_read_space (rs_r),
        .left_channel_data             (dat_l),
        .right_channel_data            (dat_r)
`ifdef AUDIO_IN_OVERFLOW_CNT_EN
        ,
        .overflow_count                (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First W bits of the frame, MSB first, zero-filled when short.
    function automatic logic [31:0] justify();
        logic [31:0] w = '0;
        for (int i = 0; i < fbits.size() && i < W; i++) w[W-1-i] = fbits[i];
        return w;
    endfunction

    function automatic logic [31:0] space_of(input int n);
        return (n == DEPTH) ? 32'h80 : 32'(n);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ql.delete(); qr.delete(); fbits.delete();
        phase = 0; m_ovf = 0;
    endtask

    task automatic lr_rise(input bit pop_l = 1'b0, input bit pop_r = 1'b0);
        if (pop_l && ql.size() > 0) void'(ql.pop_front());
        if (pop_r && qr.size() > 0) void'(qr.pop_front());
        if (phase == 2) begin
            if (ql.size() < DEPTH && qr.size() < DEPTH) begin
                ql.push_back(left_word);
                qr.push_back(justify());
            end else if (m_ovf < 65535) begin
                m_ovf++;
            end
        end
        phase = 1;
        fbits.delete();
        lr_r = 1'b1; rd_l = pop_l; rd_r = pop_r;
        tick();
        lr_r = 1'b0; rd_l = 1'b0; rd_r = 1'b0;
    endtask

    task automatic lr_fall();
        if (phase == 1) begin
            left_word = justify();
            phase = 2;
        end
        fbits.delete();
        lr_f = 1'b1;
        tick();
        lr_f = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            sdata = s[63-i];
            tick();
            bclk_r = 1'b1;
            tick();
            bclk_r = 1'b0;
            if (phase != 0) fbits.push_back(s[63-i]);
        end
    endtask

    task automatic send_pair(input logic [63:0] l, input int nl, input logic [63:0] r, input int nr);
        lr_rise();
        send_bits(l, nl);
        lr_fall();
        send_bits(r, nr);
    endtask

    task automatic pop(input bit l, input bit r);
        if (l && ql.size() > 0) void'(ql.pop_front());
        if (r && qr.size() > 0) void'(qr.pop_front());
        rd_l = l; rd_r = r;
        tick();
        rd_l = 1'b0; rd_r = 1'b0;
    endtask

    // One idle cycle lets read_space catch up, then compare everything.
    task automatic check_settled(input string tag);
        tick();
        chk({tag, "_rs_l"}, 32'(rs_l), space_of(ql.size()));
        chk({tag, "_rs_r"}, 32'(rs_r), space_of(qr.size()));
        if (ql.size() > 0) chk({tag, "_dat_l"}, dat_l, ql[0]);
        if (qr.size() > 0) chk({tag, "_dat_r"}, dat_r, qr[0]);
`ifdef AUDIO_IN_OVERFLOW_CNT_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
`endif
    endtask

    initial begin
        // Reset state.
        tick();
        do_reset();
        chk("rst_rs_l", 32'(rs_l), 32'h0);
        chk("rst_rs_r", 32'(rs_r), 32'h0);
        chk("rst_dat_l", dat_l, 32'h0);
        chk("rst_dat_r", dat_r, 32'h0);

        // Basic pair and commit latency.
        send_pair({32'hA5A5_0001, 32'h0}, 32, {32'h5A5A_0002, 32'h0}, 32);
        lr_rise();
        chk("t1_dat_l_n1", dat_l, 32'hA5A5_0001);
        chk("t1_dat_r_n1", dat_r, 32'h5A5A_0002);
        chk("t1_rs_l_n1", 32'(rs_l), 32'h0);
        tick();
        chk("t1_rs_l_n2", 32'(rs_l), 32'h1);
        chk("t1_rs_r_n2", 32'(rs_r), 32'h1);
        check_settled("t1");
        pop(1'b1, 1'b1);
        check_settled("t1_popped");
        pop(1'b1, 1'b1);
        check_settled("t1_empty_pop");

        // Mid-frame start: nothing written before a full pair.
        do_reset();
        lr_fall();
        send_bits({$urandom, $urandom}, 10);
        check_settled("t2_partial");
        lr_rise();
        send_bits({$urandom, $urandom}, 32);
        lr_fall();
        send_bits({$urandom, $urandom}, 32);
        check_settled("t2_nocommit");
        lr_rise();
        check_settled("t2_commit");

        // Long left frame, short right frame.
        send_pair({32'h1234_5678, 8'hFF, 24'h0}, 40, {16'hFFFF, 48'h0}, 16);
        lr_rise();
        pop(1'b1, 1'b1);
        check_settled("t3_lengths");
        chk("t3_long_left", dat_l, 32'h1234_5678);
        chk("t3_short_right", dat_r, 32'hFFFF_0000);
        for (int k = 0; k < 6; k++) begin
            send_pair({$urandom, $urandom}, int'($urandom_range(1, 40)),
                      {$urandom, $urandom}, int'($urandom_range(1, 40)));
        end
        lr_rise();
        check_settled("t3_rand");
        for (int k = 0; k < 7; k++) begin
            pop(1'b1, 1'b1);
            check_settled("t3_drain");
        end

        // Fill to full, then drops.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            send_pair({$urandom, $urandom}, int'($urandom_range(1, 32)),
                      {$urandom, $urandom}, int'($urandom_range(1, 32)));
        end
        lr_rise();
        check_settled("t4_full");
        chk("t4_full_rs", 32'(rs_l), 32'h80);
        send_bits({$urandom, $urandom}, 8);
        lr_fall();
        send_bits({$urandom, $urandom}, 8);
        lr_rise();
        check_settled("t4_drop1");
        pop(1'b1, 1'b0);
        check_settled("t4_pop_left");
        send_bits({$urandom, $urandom}, 8);
        lr_fall();
        send_bits({$urandom, $urandom}, 8);
        lr_rise();
        check_settled("t4_drop2");
        chk("t4_left_127", 32'(rs_l), 32'd127);
`ifdef AUDIO_IN_OVERFLOW_CNT_EN
        chk("t4_ovf_2", 32'(ovf), 32'd2);
`endif

        // Commit coinciding with a left pop at 5 stored words.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_pair({$urandom, $urandom}, 32, {$urandom, $urandom}, 32);
        end
        lr_rise();
        send_bits({$urandom, $urandom}, 32);
        lr_fall();
        send_bits({$urandom, $urandom}, 32);
        check_settled("t5_before");
        lr_rise(1'b1, 1'b0);
        check_settled("t5_after");
        chk("t5_left_5", 32'(rs_l), 32'd5);

        // Reset in the middle of a left frame.
        lr_rise();
        send_bits({$urandom, $urandom}, 20);
        do_reset();
        chk("t6_rs_l", 32'(rs_l), 32'h0);
        chk("t6_rs_r", 32'(rs_r), 32'h0);
        chk("t6_dat_l", dat_l, 32'h0);
        chk("t6_dat_r", dat_r, 32'h0);
        send_pair({32'hCAFE_F00D, 32'h0}, 32, {32'h0BAD_BEEF, 32'h0}, 32);
        lr_rise();
        check_settled("t6_recover");
        chk("t6_left_word", dat_l, 32'hCAFE_F00D);
        chk("t6_right_word", dat_r, 32'h0BAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
